// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels of both clients plus the shared ALU port
interface alu_arbiter_if #(parameter int WIDTH = 16, parameter int OPW = 4);
  logic             req0_valid, req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp0_err;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid, rsp1_ready, rsp1_err;
  logic [WIDTH-1:0] rsp1_data;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             busy;
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_out,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_err,
           rsp1_valid, rsp1_data, rsp1_err, alu_a, alu_b, alu_op, busy
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_out,
    output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_err,
           rsp1_valid, rsp1_data, rsp1_err, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// one op in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input logic      clk,
  input logic      rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t           state, next;
  logic             rr_ptr, owner, err, grant1, take, done, err0, err1;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] data0, data1, result;
  // requester 1 wins when alone or when both ask and it is its turn
  assign grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr);
  assign take   = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
  assign done   = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);
  assign sel_op = grant1 ? bus.req1_op : bus.req0_op;
  assign result = err ? '0 : bus.alu_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end
  always_comb begin
    next = state == IDLE ? (take ? EXEC : IDLE) :
           state == EXEC ? RESP :
           (state == RESP && !done) ? RESP : IDLE;
  end
  // ready is masked by rst_n so a held request is never acknowledged during reset
  always_comb begin
    bus.req0_ready = rst_n & (state == IDLE) & bus.req0_valid & ~grant1;
    bus.req1_ready = rst_n & (state == IDLE) & grant1;
    bus.rsp0_valid = (state == RESP) & ~owner;
    bus.rsp1_valid = (state == RESP) & owner;
    bus.rsp0_data  = data0;
    bus.rsp1_data  = data1;
    bus.rsp0_err   = err0;
    bus.rsp1_err   = err1;
    bus.busy       = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= '0;
      owner      <= 1'b0;
      err        <= 1'b0;
      rr_ptr     <= 1'b0;
      data0      <= '0;
      data1      <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      if (take) begin
        bus.alu_a  <= grant1 ? bus.req1_a : bus.req0_a;
        bus.alu_b  <= grant1 ? bus.req1_b : bus.req0_b;
        bus.alu_op <= sel_op;
        owner      <= grant1;
        err        <= sel_op > OPW'(3);
      end
      if (state == EXEC && owner) begin
        data1 <= result;
        err1  <= err;
      end
      if (state == EXEC && !owner) begin
        data0 <= result;
        err0  <= err;
      end
      if (done) rr_ptr <= ~owner;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests of the shared-ALU arbiter with a behavioural ALU.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  alu_arbiter_if #(.WIDTH(16), .OPW(4)) bus ();
  alu_arbiter #(.WIDTH(16), .OPW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    case (bus.alu_op)
      4'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_out = bus.alu_a & bus.alu_b;
      4'd3:    bus.alu_out = bus.alu_a | bus.alu_b;
      default: bus.alu_out = 16'hBEEF;
    endcase
  end
  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
  endtask
  // drives one op on port n and returns the response seen; ok=0 on timeout
  task automatic do_op(input bit n, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] d, output logic e, output bit ok);
    int t;
    @(negedge clk);
    if (n) begin bus.req1_valid = 1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; end
    else   begin bus.req0_valid = 1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; end
    t = 0;
    #1;
    while (!(n ? bus.req1_ready : bus.req0_ready) && t < 20) begin @(negedge clk); #1; t++; end
    ok = t < 20;
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    t = 0;
    #1;
    while (!(n ? bus.rsp1_valid : bus.rsp0_valid) && t < 20) begin @(negedge clk); #1; t++; end
    ok = ok && t < 20;
    d = n ? bus.rsp1_data : bus.rsp0_data;
    e = n ? bus.rsp1_err : bus.rsp0_err;
    @(negedge clk);
  endtask
  task automatic test_reset();
    bus.req0_valid = 1;
    #3;
    compared++; if (bus.req0_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got=%b want=0", bus.req0_ready); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    compared++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err} !== 4'b0) begin mismatched++; $display("FAIL reset_rsp got=%b want=0000", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err}); end
    compared++; if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp0_data, bus.rsp1_data} !== 68'b0) begin mismatched++; $display("FAIL reset_data got=%h want=0", {bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp0_data, bus.rsp1_data}); end
    bus.req0_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.rsp0_ready = 1;
    #1;
    compared++; if (bus.req0_ready !== 1'b1) begin mismatched++; $display("FAIL single_ready_T got=%b want=1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 0;
    #1;
    compared++; if ({bus.busy, bus.rsp0_valid} !== 2'b10) begin mismatched++; $display("FAIL single_exec busy,valid got=%b want=10", {bus.busy, bus.rsp0_valid}); end
    @(negedge clk);
    #1;
    compared++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10) begin mismatched++; $display("FAIL single_valid_T2 got=%b want=10", {bus.rsp0_valid, bus.rsp1_valid}); end
    compared++; if (bus.rsp0_data !== 16'h0007) begin mismatched++; $display("FAIL single_data got=%h want=0007", bus.rsp0_data); end
    compared++; if (bus.rsp0_err !== 1'b0) begin mismatched++; $display("FAIL single_err got=%b want=0", bus.rsp0_err); end
    @(negedge clk);
    #1;
    compared++; if ({bus.rsp0_valid, bus.busy} !== 2'b00) begin mismatched++; $display("FAIL single_done valid,busy got=%b want=00", {bus.rsp0_valid, bus.busy}); end
  endtask
  task automatic test_wrap();
    logic [15:0] d; logic e; bit ok;
    do_op(1, 4'd1, 16'h0000, 16'h0001, d, e, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL wrap_sub_timeout got=%b want=1", ok); end
    compared++; if (d !== 16'hFFFF) begin mismatched++; $display("FAIL wrap_sub got=%h want=ffff", d); end
    do_op(0, 4'd0, 16'hFFFF, 16'h0002, d, e, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL wrap_add_timeout got=%b want=1", ok); end
    compared++; if (d !== 16'h0001) begin mismatched++; $display("FAIL wrap_add got=%h want=0001", d); end
  endtask
  task automatic test_reset_mid_exec();
    bit seen = 0;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 16'h0011; bus.req0_b = 16'h0022;
    @(negedge clk);
    bus.req0_valid = 0;
    #1;
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL midreset_pre_busy got=%b want=1", bus.busy); end
    #1 rst_n = 0;
    #1;
    compared++; if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 5'b0) begin mismatched++; $display("FAIL midreset_state got=%b want=00000", {bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready}); end
    compared++; if (bus.alu_a !== 16'h0) begin mismatched++; $display("FAIL midreset_alu_a got=%h want=0000", bus.alu_a); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      #1 if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) seen = 1;
      @(negedge clk);
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL midreset_ghost_rsp got=%b want=0", seen); end
  endtask
  task automatic test_contention();
    bit g[$];
    bit exp_g[4] = '{0, 1, 0, 1};
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_op = 4'd2; bus.req0_a = 16'hF0F0; bus.req0_b = 16'h0FF0;
    bus.req1_valid = 1; bus.req1_op = 4'd3; bus.req1_a = 16'h1200; bus.req1_b = 16'h0034;
    for (int i = 0; i < 12; i++) begin
      #1;
      compared++; if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin mismatched++; $display("FAIL cont_both_ready cycle=%0d got=1 want=0", i); end
      if (bus.req0_ready) g.push_back(0);
      if (bus.req1_ready) g.push_back(1);
      if (bus.rsp0_valid) begin
        compared++; if ({bus.rsp1_valid, bus.rsp0_data} !== {1'b0, 16'h00F0}) begin mismatched++; $display("FAIL cont_rsp0 got=%b/%h want=0/00f0", bus.rsp1_valid, bus.rsp0_data); end
      end
      if (bus.rsp1_valid) begin
        compared++; if ({bus.rsp0_valid, bus.rsp1_data} !== {1'b0, 16'h1234}) begin mismatched++; $display("FAIL cont_rsp1 got=%b/%h want=0/1234", bus.rsp0_valid, bus.rsp1_data); end
      end
      @(negedge clk);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    compared++; if (g.size() !== 4) begin mismatched++; $display("FAIL cont_grant_count got=%0d want=4", g.size()); end
    for (int i = 0; i < 4 && i < g.size(); i++) begin
      compared++; if (g[i] !== exp_g[i]) begin mismatched++; $display("FAIL cont_grant[%0d] got=%0d want=%0d", i, g[i], exp_g[i]); end
    end
  endtask
  task automatic test_back_to_back();
    logic [6:0] pat = 0;
    bit r0 = 0;
    @(negedge clk);
    bus.req1_valid = 1; bus.req1_op = 4'd0; bus.req1_a = 16'h0001; bus.req1_b = 16'h0001;
    for (int i = 0; i < 7; i++) begin
      #1 pat[6 - i] = bus.req1_ready;
      r0 |= bus.req0_ready;
      @(negedge clk);
    end
    bus.req1_valid = 0;
    compared++; if (pat !== 7'b1001001) begin mismatched++; $display("FAIL b2b_grants got=%b want=1001001", pat); end
    compared++; if (r0 !== 1'b0) begin mismatched++; $display("FAIL b2b_req0_ready got=%b want=0", r0); end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_backpressure();
    int t = 0;
    @(negedge clk);
    bus.rsp0_ready = 0;
    bus.req0_valid = 1; bus.req0_op = 4'd0; bus.req0_a = 16'd10; bus.req0_b = 16'd20;
    @(negedge clk);
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_op = 4'd1; bus.req1_a = 16'd9; bus.req1_b = 16'd4;
    #1;
    while (!bus.rsp0_valid && t < 20) begin @(negedge clk); #1; t++; end
    compared++; if (t >= 20) begin mismatched++; $display("FAIL bp_timeout got=%0d want<20", t); end
    for (int i = 0; i < 10; i++) begin
      compared++; if ({bus.rsp0_valid, bus.busy, bus.req1_ready, bus.rsp1_valid} !== 4'b1100) begin mismatched++; $display("FAIL bp_hold cycle=%0d valid,busy,r1rdy,rsp1 got=%b want=1100", i, {bus.rsp0_valid, bus.busy, bus.req1_ready, bus.rsp1_valid}); end
      compared++; if (bus.rsp0_data !== 16'd30) begin mismatched++; $display("FAIL bp_data cycle=%0d got=%h want=001e", i, bus.rsp0_data); end
      @(negedge clk);
      #1;
    end
    bus.rsp0_ready = 1;
    @(negedge clk);
    #1;
    compared++; if ({bus.rsp0_valid, bus.req1_ready} !== 2'b01) begin mismatched++; $display("FAIL bp_release valid0,r1rdy got=%b want=01", {bus.rsp0_valid, bus.req1_ready}); end
    @(negedge clk);
    bus.req1_valid = 0;
    @(negedge clk);
    #1;
    compared++; if ({bus.rsp1_valid, bus.rsp1_data} !== {1'b1, 16'd5}) begin mismatched++; $display("FAIL bp_req1_rsp got=%b/%h want=1/0005", bus.rsp1_valid, bus.rsp1_data); end
    @(negedge clk);
  endtask
  task automatic test_illegal();
    logic [15:0] d; logic e; bit ok;
    do_op(0, 4'h9, 16'd5, 16'd5, d, e, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL illegal_timeout got=%b want=1", ok); end
    compared++; if ({e, d} !== {1'b1, 16'h0000}) begin mismatched++; $display("FAIL illegal_rsp err/data got=%b/%h want=1/0000", e, d); end
    do_op(0, 4'd1, 16'd5, 16'd3, d, e, ok);
    compared++; if ({ok, e, d} !== {1'b1, 1'b0, 16'h0002}) begin mismatched++; $display("FAIL legal_after ok/err/data got=%b/%b/%h want=1/0/0002", ok, e, d); end
    repeat (2) @(negedge clk);
    #1;
    compared++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {16'd5, 16'd3, 4'd1}) begin mismatched++; $display("FAIL alu_hold got=%h/%h/%h want=0005/0003/1", bus.alu_a, bus.alu_b, bus.alu_op); end
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_wrap();
    test_reset_mid_exec();
    test_contention();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
